// File: rtl/l1b_denetleyici.sv
// Instruction-fetch responder with a single 16-byte line buffer, 4-beat refill
// on miss, valid/ready delivery to decode and an advance pulse for the PC generator.
module l1b_denetleyici #(
  parameter int ADRES_GENISLIGI = 32,
  parameter int VERI_GENISLIGI  = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [ADRES_GENISLIGI-1:0] ps_adres_i,
  input  logic                       getir_iptal_i,
  output logic                       getir_sonraki_buyruk_getir_o,
  output logic [VERI_GENISLIGI-1:0]  buyruk_o,
  output logic [ADRES_GENISLIGI-1:0] buyruk_ps_o,
  output logic                       buyruk_gecerli_o,
  input  logic                       coz_hazir_i,
  output logic                       bellek_istek_gecerli_o,
  input  logic                       bellek_istek_hazir_i,
  output logic [ADRES_GENISLIGI-1:0] bellek_adres_o,
  input  logic                       bellek_yanit_gecerli_i,
  input  logic [VERI_GENISLIGI-1:0]  bellek_yanit_veri_i
);

  localparam int ETIKET_GENISLIGI = ADRES_GENISLIGI - 4;

  typedef enum logic [1:0] {
    BOSTA,
    ISTEK,
    DOLDUR
  } durum_t;

  durum_t                       durum_q, durum_d;
  logic [1:0]                   sayac_q;
  logic [VERI_GENISLIGI-1:0]    satir_veri [4];
  logic [ETIKET_GENISLIGI-1:0]  satir_etiket_q;
  logic                         satir_gecerli_q;

  logic isabet;
  logic cikis_serbest;
  logic yukle;
  logic iskala_baslat;
  logic beat_al;
  logic son_beat;
  logic unused_ps_alt;

  // Byte offset within a word never matters for a word-aligned fetch.
  assign unused_ps_alt = ^ps_adres_i[1:0];

  assign isabet        = satir_gecerli_q &&
                         (ps_adres_i[ADRES_GENISLIGI-1:4] == satir_etiket_q);
  assign cikis_serbest = !buyruk_gecerli_o || coz_hazir_i;
  assign beat_al       = (durum_q == DOLDUR) && bellek_yanit_gecerli_i;
  assign son_beat      = beat_al && (sayac_q == 2'd3);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum_q <= BOSTA;
    end else begin
      durum_q <= durum_d;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    durum_d                = durum_q;
    yukle                  = 1'b0;
    iskala_baslat          = 1'b0;
    bellek_istek_gecerli_o = 1'b0;
    unique case (durum_q)
      BOSTA: begin
        if (!getir_iptal_i) begin
          if (isabet) begin
            yukle = cikis_serbest;
          end else begin
            iskala_baslat = 1'b1;
            durum_d       = ISTEK;
          end
        end
      end
      ISTEK: begin
        bellek_istek_gecerli_o = 1'b1;
        if (bellek_istek_hazir_i) begin
          durum_d = DOLDUR;
        end
      end
      DOLDUR: begin
        if (son_beat) begin
          durum_d = BOSTA;
        end
      end
      default: durum_d = BOSTA;
    endcase
  end

  assign getir_sonraki_buyruk_getir_o = yukle;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sayac_q          <= 2'd0;
      satir_etiket_q   <= '0;
      satir_gecerli_q  <= 1'b0;
      buyruk_o         <= '0;
      buyruk_ps_o      <= '0;
      buyruk_gecerli_o <= 1'b0;
      bellek_adres_o   <= '0;
    end else begin
      if (iskala_baslat) begin
        bellek_adres_o  <= {ps_adres_i[ADRES_GENISLIGI-1:4], 4'b0000};
        satir_gecerli_q <= 1'b0;
      end

      if ((durum_q == ISTEK) && bellek_istek_hazir_i) begin
        sayac_q <= 2'd0;
      end else if (beat_al) begin
        sayac_q <= sayac_q + 2'd1;
      end

      if (son_beat) begin
        satir_etiket_q  <= bellek_adres_o[ADRES_GENISLIGI-1:4];
        satir_gecerli_q <= 1'b1;
      end

      // Flush dominates; otherwise a load refills the slot, else decode drains it.
      if (getir_iptal_i) begin
        buyruk_gecerli_o <= 1'b0;
      end else if (yukle) begin
        buyruk_o         <= satir_veri[ps_adres_i[3:2]];
        buyruk_ps_o      <= ps_adres_i;
        buyruk_gecerli_o <= 1'b1;
      end else if (coz_hazir_i) begin
        buyruk_gecerli_o <= 1'b0;
      end
    end
  end

  // NOTE: line data is not reset; satir_gecerli_q alone guards it from being used.
  always_ff @(posedge clk_i) begin
    if (beat_al) begin
      satir_veri[sayac_q] <= bellek_yanit_veri_i;
    end
  end

endmodule

// File: tb/tb_l1b_denetleyici.sv
// Directed self-checking bench for l1b_denetleyici: refill, hits, stalls,
// flushes, memory backpressure, gapped beats and asynchronous reset.
module tb_l1b_denetleyici;

  localparam int AG = 32;
  localparam int VG = 32;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [AG-1:0] ps_adres_i;
  logic          getir_iptal_i;
  logic          getir_sonraki_buyruk_getir_o;
  logic [VG-1:0] buyruk_o;
  logic [AG-1:0] buyruk_ps_o;
  logic          buyruk_gecerli_o;
  logic          coz_hazir_i;
  logic          bellek_istek_gecerli_o;
  logic          bellek_istek_hazir_i;
  logic [AG-1:0] bellek_adres_o;
  logic          bellek_yanit_gecerli_i;
  logic [VG-1:0] bellek_yanit_veri_i;

  int vektor_sayisi = 0;
  int hata_sayisi   = 0;

  always #5 clk_i = ~clk_i;

  l1b_denetleyici #(
    .ADRES_GENISLIGI(AG),
    .VERI_GENISLIGI (VG)
  ) dut (
    .clk_i                       (clk_i),
    .rst_i                       (rst_i),
    .ps_adres_i                  (ps_adres_i),
    .getir_iptal_i               (getir_iptal_i),
    .getir_sonraki_buyruk_getir_o(getir_sonraki_buyruk_getir_o),
    .buyruk_o                    (buyruk_o),
    .buyruk_ps_o                 (buyruk_ps_o),
    .buyruk_gecerli_o            (buyruk_gecerli_o),
    .coz_hazir_i                 (coz_hazir_i),
    .bellek_istek_gecerli_o      (bellek_istek_gecerli_o),
    .bellek_istek_hazir_i        (bellek_istek_hazir_i),
    .bellek_adres_o              (bellek_adres_o),
    .bellek_yanit_gecerli_i      (bellek_yanit_gecerli_i),
    .bellek_yanit_veri_i         (bellek_yanit_veri_i)
  );

  task automatic check(input string etiket, input logic [63:0] gozlenen,
                       input logic [63:0] beklenen);
    vektor_sayisi++;
    if (gozlenen !== beklenen) begin
      hata_sayisi++;
      $display("FAIL %s: gozlenen=%0h beklenen=%0h (t=%0t)", etiket, gozlenen, beklenen, $time);
    end
  endtask

  // Step to 1 time unit after the next rising edge.
  task automatic kenar();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cikislar_sifir(input string etiket);
    check({etiket, "_buyruk"},   buyruk_o, 0);
    check({etiket, "_ps"},       buyruk_ps_o, 0);
    check({etiket, "_gecerli"},  buyruk_gecerli_o, 0);
    check({etiket, "_ilerle"},   getir_sonraki_buyruk_getir_o, 0);
    check({etiket, "_istek"},    bellek_istek_gecerli_o, 0);
    check({etiket, "_adres"},    bellek_adres_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL zaman_asimi: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VG-1:0] satir_a [4];
    satir_a[0] = 32'h11; satir_a[1] = 32'h22; satir_a[2] = 32'h33; satir_a[3] = 32'h44;

    rst_i                  = 1'b1;
    ps_adres_i             = 32'h8000_0000;
    getir_iptal_i          = 1'b0;
    coz_hazir_i            = 1'b1;
    bellek_istek_hazir_i   = 1'b0;
    bellek_yanit_gecerli_i = 1'b0;
    bellek_yanit_veri_i    = '0;

    kenar();
    kenar();
    cikislar_sifir("reset");

    // Cold miss at 0x8000_0000.
    rst_i = 1'b0;
    #1;
    check("soguk_iskala_ilerle", getir_sonraki_buyruk_getir_o, 0);
    check("soguk_iskala_istek_yok", bellek_istek_gecerli_o, 0);
    kenar();
    check("soguk_istek", bellek_istek_gecerli_o, 1);
    check("soguk_adres", bellek_adres_o, 32'h8000_0000);
    bellek_istek_hazir_i = 1'b1;
    kenar();
    bellek_istek_hazir_i = 1'b0;
    check("doldur_istek_dustu", bellek_istek_gecerli_o, 0);
    for (int i = 0; i < 4; i++) begin
      bellek_yanit_gecerli_i = 1'b1;
      bellek_yanit_veri_i    = satir_a[i];
      #1;
      check("doldur_ilerle_yok", getir_sonraki_buyruk_getir_o, 0);
      kenar();
    end
    bellek_yanit_gecerli_i = 1'b0;
    check("doldur_sonu_gecerli_yok", buyruk_gecerli_o, 0);
    #1;
    check("ilk_isabet_ilerle", getir_sonraki_buyruk_getir_o, 1);
    kenar();
    check("ilk_buyruk", buyruk_o, 32'h11);
    check("ilk_ps", buyruk_ps_o, 32'h8000_0000);
    check("ilk_gecerli", buyruk_gecerli_o, 1);

    // Back-to-back hits, one instruction per cycle.
    for (int k = 1; k < 4; k++) begin
      ps_adres_i = 32'h8000_0000 + 32'(4 * k);
      #1;
      check("ardisik_ilerle", getir_sonraki_buyruk_getir_o, 1);
      kenar();
      check("ardisik_buyruk", buyruk_o, satir_a[k]);
      check("ardisik_ps", buyruk_ps_o, 32'h8000_0000 + 32'(4 * k));
      check("ardisik_gecerli", buyruk_gecerli_o, 1);
    end

    // Flush coinciding with a hit: no advance, no load, valid drops.
    getir_iptal_i = 1'b1;
    ps_adres_i    = 32'h8000_0000;
    #1;
    check("iptal_isabet_ilerle", getir_sonraki_buyruk_getir_o, 0);
    kenar();
    check("iptal_isabet_gecerli", buyruk_gecerli_o, 0);
    check("iptal_isabet_yukleme_yok", buyruk_o, 32'h44);
    getir_iptal_i = 1'b0;
    #1;
    check("iptal_sonrasi_ilerle", getir_sonraki_buyruk_getir_o, 1);
    kenar();
    check("iptal_sonrasi_buyruk", buyruk_o, 32'h11);

    // Decode stall for three cycles.
    ps_adres_i  = 32'h8000_0004;
    coz_hazir_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("durak_ilerle_yok", getir_sonraki_buyruk_getir_o, 0);
      kenar();
      check("durak_buyruk_sabit", buyruk_o, 32'h11);
      check("durak_ps_sabit", buyruk_ps_o, 32'h8000_0000);
      check("durak_gecerli", buyruk_gecerli_o, 1);
    end
    coz_hazir_i = 1'b1;
    #1;
    check("durak_bitti_ilerle", getir_sonraki_buyruk_getir_o, 1);
    kenar();
    check("durak_bitti_buyruk", buyruk_o, 32'h22);
    check("durak_bitti_ps", buyruk_ps_o, 32'h8000_0004);

    // Redirect to a missing line, then flush to 0x8000_0100 mid-refill.
    getir_iptal_i = 1'b1;
    ps_adres_i    = 32'h8000_0040;
    kenar();
    getir_iptal_i = 1'b0;
    #1;
    check("b_iskala_ilerle", getir_sonraki_buyruk_getir_o, 0);
    kenar();
    check("b_istek", bellek_istek_gecerli_o, 1);
    check("b_adres", bellek_adres_o, 32'h8000_0040);
    bellek_istek_hazir_i = 1'b1;
    kenar();
    bellek_istek_hazir_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bellek_yanit_gecerli_i = 1'b1;
      bellek_yanit_veri_i    = 32'hA0 + 32'(i);
      kenar();
    end
    bellek_yanit_gecerli_i = 1'b0;
    getir_iptal_i          = 1'b1;
    ps_adres_i             = 32'h8000_0100;
    #1;
    check("doldur_iptal_ilerle", getir_sonraki_buyruk_getir_o, 0);
    check("doldur_iptal_istek_yok", bellek_istek_gecerli_o, 0);
    kenar();
    getir_iptal_i = 1'b0;
    for (int i = 2; i < 4; i++) begin
      bellek_yanit_gecerli_i = 1'b1;
      bellek_yanit_veri_i    = 32'hA0 + 32'(i);
      #1;
      check("doldur_iptal_surer", getir_sonraki_buyruk_getir_o, 0);
      check("doldur_iptal_eski_yok", buyruk_gecerli_o, 0);
      kenar();
    end
    bellek_yanit_gecerli_i = 1'b0;
    #1;
    check("yeni_ps_iskala", getir_sonraki_buyruk_getir_o, 0);
    kenar();
    check("yeni_ps_istek", bellek_istek_gecerli_o, 1);
    check("yeni_ps_adres", bellek_adres_o, 32'h8000_0100);
    check("yeni_ps_eski_yok", buyruk_gecerli_o, 0);

    // Request backpressure for five cycles.
    for (int i = 0; i < 5; i++) begin
      kenar();
      check("geri_basinc_istek", bellek_istek_gecerli_o, 1);
      check("geri_basinc_adres", bellek_adres_o, 32'h8000_0100);
    end
    bellek_istek_hazir_i = 1'b1;
    kenar();
    bellek_istek_hazir_i = 1'b0;
    check("kabul_sonrasi_istek", bellek_istek_gecerli_o, 0);

    // Beats separated by two idle cycles.
    for (int i = 0; i < 4; i++) begin
      bellek_yanit_gecerli_i = 1'b1;
      bellek_yanit_veri_i    = 32'hB0 + 32'(i);
      kenar();
      bellek_yanit_gecerli_i = 1'b0;
      if (i < 3) begin
        for (int g = 0; g < 2; g++) begin
          #1;
          check("bosluk_ilerle_yok", getir_sonraki_buyruk_getir_o, 0);
          check("bosluk_istek_yok", bellek_istek_gecerli_o, 0);
          kenar();
        end
      end
    end
    #1;
    check("bosluklu_isabet", getir_sonraki_buyruk_getir_o, 1);
    kenar();
    check("bosluklu_buyruk0", buyruk_o, 32'hB0);
    check("bosluklu_ps0", buyruk_ps_o, 32'h8000_0100);
    ps_adres_i = 32'h8000_0104;
    #1;
    check("bosluklu_ilerle1", getir_sonraki_buyruk_getir_o, 1);
    kenar();
    check("bosluklu_buyruk1", buyruk_o, 32'hB1);

    // Asynchronous reset in the middle of a refill.
    getir_iptal_i = 1'b1;
    ps_adres_i    = 32'h8000_0200;
    kenar();
    getir_iptal_i = 1'b0;
    kenar();
    check("c_istek", bellek_istek_gecerli_o, 1);
    bellek_istek_hazir_i = 1'b1;
    kenar();
    bellek_istek_hazir_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bellek_yanit_gecerli_i = 1'b1;
      bellek_yanit_veri_i    = 32'hC0 + 32'(i);
      kenar();
    end
    bellek_yanit_gecerli_i = 1'b0;
    check("reset_oncesi_adres", bellek_adres_o, 32'h8000_0200);
    #1;
    rst_i = 1'b1;
    #1;
    cikislar_sifir("async_reset");
    kenar();
    rst_i = 1'b0;
    #1;
    check("reset_sonrasi_iskala", getir_sonraki_buyruk_getir_o, 0);
    kenar();
    check("reset_sonrasi_istek", bellek_istek_gecerli_o, 1);
    check("reset_sonrasi_adres", bellek_adres_o, 32'h8000_0200);

    $display("== %0d vectors applied, %0d miscompares ==", vektor_sayisi, hata_sayisi);
    $finish;
  end

endmodule
